// File: rtl/pipelined_diff_constant.sv
// Stream differencer/checker: recovers d[n] = x[n] - x[n-1] (mod 2^W) through a
// split-carry subtractor and checks each difference against a loaded constant.
module pipelined_diff_constant #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [W-1:0]     i,
  input  logic             x_vld,
  input  logic [W-1:0]     x,
  output logic             d_vld_r,
  output logic [W-1:0]     d_r,
  output logic             match_r,
  output logic             err_r,
  output logic [CNT_W-1:0] cnt_r
);

  localparam int L = W / 2;
  localparam int H = W - L;

  // Handshake: x_vld qualifies x for one cycle, there is no ready (the block
  // always accepts); d_vld_r is a one-cycle pulse qualifying d_r and match_r.

  logic [W-1:0]     i_q, i_d;
  logic             hv_q, hv_d;
  logic [W-1:0]     prev_q, prev_d;
  logic             s0_vld_q, s0_vld_d;
  logic [W-1:0]     s0_x_q, s0_x_d;
  logic [W-1:0]     s0_p_q, s0_p_d;
  logic             s1_vld_q, s1_vld_d;
  logic [L-1:0]     s1_lo_q, s1_lo_d;
  logic             s1_c_q, s1_c_d;
  logic [H-1:0]     s1_xhi_q, s1_xhi_d;
  logic [H-1:0]     s1_phin_q, s1_phin_d;
  logic             d_vld_q, d_vld_d;
  logic [W-1:0]     d_q, d_d;
  logic             match_q, match_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic [L:0]       lo_sum;
  logic [H-1:0]     hi_sum;
  logic [W-1:0]     diff;
  logic             diff_ok;

  always_comb begin
    i_d       = i_q;
    hv_d      = hv_q;
    prev_d    = prev_q;
    s0_vld_d  = 1'b0;
    s0_x_d    = s0_x_q;
    s0_p_d    = s0_p_q;
    s1_vld_d  = s0_vld_q;
    s1_lo_d   = s1_lo_q;
    s1_c_d    = s1_c_q;
    s1_xhi_d  = s1_xhi_q;
    s1_phin_d = s1_phin_q;
    d_vld_d   = s1_vld_q;
    d_d       = d_q;
    match_d   = match_q;
    err_d     = err_q;
    cnt_d     = cnt_q;

    accept  = x_vld & ~init;
    lo_sum  = {1'b0, s0_x_q[L-1:0]} + {1'b0, ~s0_p_q[L-1:0]} + {{L{1'b0}}, 1'b1};
    hi_sum  = s1_xhi_q + s1_phin_q + {{(H-1){1'b0}}, s1_c_q};
    diff    = {hi_sum, s1_lo_q};
    diff_ok = (diff == i_q);

    // The first sample after init/reset only becomes the reference.
    if (accept) begin
      prev_d = x;
      hv_d   = 1'b1;
      if (hv_q) begin
        s0_vld_d = 1'b1;
        s0_x_d   = x;
        s0_p_d   = prev_q;
      end
    end

    if (s0_vld_q) begin
      s1_lo_d   = lo_sum[L-1:0];
      s1_c_d    = lo_sum[L];
      s1_xhi_d  = s0_x_q[W-1:L];
      s1_phin_d = ~s0_p_q[W-1:L];
    end

    if (s1_vld_q) begin
      d_d     = diff;
      match_d = diff_ok;
      err_d   = err_q | ~diff_ok;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // init flushes everything in flight and restarts history and statistics.
    if (init) begin
      i_d      = i;
      hv_d     = 1'b0;
      s0_vld_d = 1'b0;
      s1_vld_d = 1'b0;
      d_vld_d  = 1'b0;
      err_d    = 1'b0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q       <= '0;
      hv_q      <= 1'b0;
      prev_q    <= '0;
      s0_vld_q  <= 1'b0;
      s0_x_q    <= '0;
      s0_p_q    <= '0;
      s1_vld_q  <= 1'b0;
      s1_lo_q   <= '0;
      s1_c_q    <= 1'b0;
      s1_xhi_q  <= '0;
      s1_phin_q <= '0;
      d_vld_q   <= 1'b0;
      d_q       <= '0;
      match_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      i_q       <= i_d;
      hv_q      <= hv_d;
      prev_q    <= prev_d;
      s0_vld_q  <= s0_vld_d;
      s0_x_q    <= s0_x_d;
      s0_p_q    <= s0_p_d;
      s1_vld_q  <= s1_vld_d;
      s1_lo_q   <= s1_lo_d;
      s1_c_q    <= s1_c_d;
      s1_xhi_q  <= s1_xhi_d;
      s1_phin_q <= s1_phin_d;
      d_vld_q   <= d_vld_d;
      d_q       <= d_d;
      match_q   <= match_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign d_vld_r = d_vld_q;
  assign d_r     = d_q;
  assign match_r = match_q;
  assign err_r   = err_q;
  assign cnt_r   = cnt_q;

endmodule

// File: tb/tb_pipelined_diff_constant.sv
// Directed bench for pipelined_diff_constant: drivers push hand-computed
// expectations (with arrival cycle) into a queue popped by a monitor.
module tb_pipelined_diff_constant;

  localparam int W     = 32;
  localparam int CNT_W = 16;
  localparam int EXP_W = 16 + 1 + 1 + CNT_W + W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             init = 1'b0;
  logic [W-1:0]     i = '0;
  logic             x_vld = 1'b0;
  logic [W-1:0]     x = '0;
  logic             d_vld_r;
  logic [W-1:0]     d_r;
  logic             match_r;
  logic             err_r;
  logic [CNT_W-1:0] cnt_r;
  logic             s_d_vld_r;
  logic [W-1:0]     s_d_r;
  logic             s_match_r;
  logic             s_err_r;
  logic [1:0]       s_cnt_r;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [EXP_W-1:0] exp_q[$];

  pipelined_diff_constant #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .init(init), .i(i), .x_vld(x_vld), .x(x),
    .d_vld_r(d_vld_r), .d_r(d_r), .match_r(match_r), .err_r(err_r), .cnt_r(cnt_r)
  );

  pipelined_diff_constant #(.W(W), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .init(init), .i(i), .x_vld(x_vld), .x(x),
    .d_vld_r(s_d_vld_r), .d_r(s_d_r), .match_r(s_match_r), .err_r(s_err_r), .cnt_r(s_cnt_r)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    logic [EXP_W-1:0] a;
    logic [CNT_W-1:0] ecnt;
    logic [1:0]       esat;
    while (exp_q.size() > 0 && int'(exp_q[0][EXP_W-1 -: 16]) < cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_pulse: no d_vld_r at cycle %0d, expected d=0x%0h", e[EXP_W-1 -: 16], e[W-1:0]);
    end
    if (d_vld_r === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: d_vld_r at cycle %0d d_r=0x%0h, none expected", cyc, d_r);
      end else begin
        e = exp_q.pop_front();
        a = {16'(cyc), err_r, match_r, cnt_r, d_r};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL diff_out: got cyc/err/match/cnt/d=0x%0h expected 0x%0h", a, e);
        end
        ecnt = e[W +: CNT_W];
        esat = (ecnt > 3) ? 2'd3 : ecnt[1:0];
        n_checks++;
        if (s_d_vld_r !== 1'b1 || s_cnt_r !== esat) begin
          n_fail++;
          $display("FAIL sat_cnt: got vld=%0b cnt=%0d expected vld=1 cnt=%0d", s_d_vld_r, s_cnt_r, esat);
        end
      end
    end
  end

  // drivers
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      x_vld = 1'b0;
      init  = 1'b0;
    end
  endtask

  task automatic send(input logic [W-1:0] v, input bit has_exp, input logic [W-1:0] ed,
                      input bit em, input bit ee, input logic [CNT_W-1:0] ec);
    @(negedge clk);
    init  = 1'b0;
    x_vld = 1'b1;
    x     = v;
    if (has_exp) exp_q.push_back({16'(cyc + 3), ee, em, ec, ed});
  endtask

  task automatic do_init(input logic [W-1:0] v);
    @(negedge clk);
    x_vld = 1'b0;
    init  = 1'b1;
    i     = v;
    @(negedge clk);
    init = 1'b0;
    check("init_err", 64'(err_r), 64'd0);
    check("init_cnt", 64'(cnt_r), 64'd0);
    check("init_vld", 64'(d_vld_r), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_vld", 64'(d_vld_r), 64'd0);
    check("rst_d", 64'(d_r), 64'd0);
    check("rst_match", 64'(match_r), 64'd0);
    check("rst_err", 64'(err_r), 64'd0);
    check("rst_cnt", 64'(cnt_r), 64'd0);

    // basic constant stream
    do_init(32'd3);
    send(32'd10, 0, 0, 0, 0, 0);
    send(32'd13, 1, 32'd3, 1, 0, 16'd1);
    send(32'd16, 1, 32'd3, 1, 0, 16'd2);
    send(32'd19, 1, 32'd3, 1, 0, 16'd3);
    idle(4);
    check("basic_cnt", 64'(cnt_r), 64'd3);

    // carry between halves, then 2^W wrap
    do_init(32'd3);
    send(32'h0000_FFFF, 0, 0, 0, 0, 0);
    send(32'h0001_0002, 1, 32'd3, 1, 0, 16'd1);
    idle(3);
    do_init(32'd3);
    send(32'hFFFF_FFFE, 0, 0, 0, 0, 0);
    send(32'h0000_0001, 1, 32'd3, 1, 0, 16'd1);
    idle(3);

    // mismatch and sticky error
    do_init(32'd3);
    send(32'd10, 0, 0, 0, 0, 0);
    send(32'd13, 1, 32'd3, 1, 0, 16'd1);
    send(32'd17, 1, 32'd4, 0, 1, 16'd2);
    send(32'd20, 1, 32'd3, 1, 1, 16'd3);
    idle(4);
    check("sticky_err", 64'(err_r), 64'd1);
    do_init(32'd3);

    // gaps between samples
    do_init(32'd5);
    send(32'd100, 0, 0, 0, 0, 0);
    idle(3);
    send(32'd105, 1, 32'd5, 1, 0, 16'd1);
    idle(1);
    send(32'd110, 1, 32'd5, 1, 0, 16'd2);
    idle(4);

    // init flushes in-flight diffs and discards a same-cycle sample
    do_init(32'd1);
    send(32'd0, 0, 0, 0, 0, 0);
    send(32'd1, 0, 0, 0, 0, 0);
    send(32'd2, 0, 0, 0, 0, 0);
    @(negedge clk);
    init  = 1'b1;
    i     = 32'd7;
    x_vld = 1'b1;
    x     = 32'd9;
    @(negedge clk);
    init  = 1'b0;
    x_vld = 1'b0;
    check("flush_vld", 64'(d_vld_r), 64'd0);
    check("flush_cnt", 64'(cnt_r), 64'd0);
    idle(2);
    send(32'd20, 0, 0, 0, 0, 0);
    send(32'd27, 1, 32'd7, 1, 0, 16'd1);
    idle(4);

    // reset with two diffs in flight
    do_init(32'd3);
    send(32'd1, 0, 0, 0, 0, 0);
    send(32'd4, 0, 0, 0, 0, 0);
    send(32'd7, 0, 0, 0, 0, 0);
    @(negedge clk);
    x_vld = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    check("mrst_vld", 64'(d_vld_r), 64'd0);
    check("mrst_d", 64'(d_r), 64'd0);
    check("mrst_match", 64'(match_r), 64'd0);
    check("mrst_err", 64'(err_r), 64'd0);
    check("mrst_cnt", 64'(cnt_r), 64'd0);
    rst = 1'b0;
    idle(4);

    // counter saturation on the CNT_W=2 instance
    do_init(32'd2);
    send(32'd0, 0, 0, 0, 0, 0);
    send(32'd2, 1, 32'd2, 1, 0, 16'd1);
    send(32'd4, 1, 32'd2, 1, 0, 16'd2);
    send(32'd6, 1, 32'd2, 1, 0, 16'd3);
    send(32'd8, 1, 32'd2, 1, 0, 16'd4);
    send(32'd10, 1, 32'd2, 1, 0, 16'd5);
    idle(5);
    check("sat_final", 64'(s_cnt_r), 64'd3);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_diff_constant.md
# pipelined_diff_constant

Receive-side counterpart of the pipelined constant accumulator. It takes a stream of accumulated values x[n] and recovers each difference d[n] = x[n] − x[n−1] (mod 2^W) through a two-cycle split subtractor. It checks every difference against the expected constant loaded at init. It sits at the consumer end of an accumulator stream as a decoder/checker, reporting per-sample match, a sticky error and a difference count.

## Interface
- W, 32, datapath width; legal W ≥ 2; low half L = W/2 (floor), high half H = W − L
- CNT_W, 16, width of the difference counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- init  in  1  load expected constant, clear history, counter and error, flush pipeline
- i  in  W  expected constant; sampled only when init=1
- x_vld  in  1  x is a valid accumulated sample this cycle
- x  in  W  accumulated sample
- d_vld_r  out  1  registered; d_r/match_r valid this cycle
- d_r  out  W  registered difference x[n] − x[n−1] mod 2^W
- match_r  out  1  registered; d_r == expected constant (qualified by d_vld_r)
- err_r  out  1  sticky; set on any mismatching difference
- cnt_r  out  CNT_W  number of differences emitted since init/rst; saturates at all-ones

## Operation
- Reset: d_vld_r=0, d_r=0, match_r=0, err_r=0, cnt_r=0, expected constant I_r=0, history-valid flag hv_r=0, all pipeline valids 0.
- init=1: I_r←i, hv_r←0, err_r←0, cnt_r←0, stage-1 and stage-2 valids cleared (in-flight samples dropped, no d_vld_r pulse for them). Any x_vld in the same cycle is discarded; init takes priority. rst has priority over init.
- Accepted sample (x_vld=1, init=0):
  - if hv_r=0: store x as prev_r, set hv_r=1, no difference produced.
  - if hv_r=1: launch subtraction x − prev_r into stage 1, then prev_r←x.
- Idle cycles (x_vld=0) hold all history; gaps of any length between samples are legal and do not affect results.
- Stage 1 (registered): low sum = x[L−1:0] + ~prev[L−1:0] + 1 (L+1 bits); register low result, carry-out, x[W−1:L] and ~prev[W−1:L]; s1_vld_r←1.
- Stage 2 (registered): high result = x_hi + ~prev_hi + carry (H bits, carry-out discarded); d_r←{high, low}; match_r←({high,low} == I_r); d_vld_r←s1_vld_r.
- On d_vld_r rising from stage 2 with mismatch: err_r←1 the same cycle match_r=0 is presented (err_r computed combinationally from stage-1 result into its flop, i.e. err_r and d_vld_r/match_r update on the same edge).
- cnt_r increments on the same edge d_vld_r is set; holds at 2^CNT_W−1.
- d_r and match_r hold their last values when d_vld_r=0.
- Arithmetic strictly modulo 2^W; wrap-around of the accumulator (x[n] < x[n−1] unsigned) yields the correct difference with no error.
- Throughput: one sample per cycle, back-to-back x_vld fully supported.

## Timing
- Latency: x sampled at edge t (second or later sample) → d_vld_r, d_r, match_r, err_r, cnt_r updated at edge t+2.
- init at edge t: I_r valid from t; first sample accepted at t+1 or later; first difference earliest at edge t+4 (samples at t+1, t+2).
- Sample accepted at edge t−1 with init at edge t: still in stage 1 at t, killed; no output.
- rst mid-stream: all outputs return to reset values on the next edge; hv_r=0, so the next sample is again a reference.
- No backpressure; output is a one-cycle pulse per difference.

## Test plan
- W=32, init i=3, then x=10,13,16,19 back-to-back → three d_vld_r pulses at edges 2 after samples 2..4, d_r=3, match_r=1, err_r=0, cnt_r=3.
- Carry across halves: i=3, x=0x0000_FFFF then 0x0001_0002 → d_r=3, match_r=1; wrap: x=0xFFFF_FFFE then 0x0000_0001 → d_r=3, match_r=1.
- Mismatch/sticky: i=3, x=10,13,17,20 → d_r=3,4,3; match_r=1,0,1; err_r rises with the d_r=4 pulse and stays 1; a following init clears err_r and cnt_r to 0.
- Gaps: i=5, x=100, idle 3 cycles, x=105, idle 1, x=110 → two pulses d_r=5, match_r=1, each exactly 2 cycles after its sample.
- Init flush: i=1, x=0,1,2 back-to-back, init (i=7) asserted on the cycle after x=2 with x_vld=1 x=9 → no pulse for x=2, x=9 discarded; then x=20,27 → single pulse d_r=7, match_r=1, cnt_r=1.
- Reset mid-stream and saturation: rst during a pipeline with two in-flight diffs → no pulses follow, all outputs 0; CNT_W=2 with 5 good diffs → cnt_r sticks at 3.
